// File: rtl/imem_prefetch_buf.sv
// Sequential instruction prefetch buffer: OBI subordinate towards the core and OBI manager
// towards instruction memory. It keeps up to DEPTH words of the current fetch stream buffered.
module imem_prefetch_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  logic          stream_valid_r;
  logic [29:0]   stream_base_r;
  logic [29:0]   fetch_addr_r;
  logic [29:0]   stale_addr_r;
  logic          stale_req_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] discard_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [31:0]   fifo_r [DEPTH];
  logic [31:0]   rdata_r;
  logic          rvalid_r;

  logic          addr_match_s;
  logic          hit_s;
  logic          miss_s;
  logic [CW-1:0] credit_s;
  logic          mem_req_s;
  logic          mem_gnt_s;
  logic          rsp_s;
  logic          push_s;
  logic [29:0]   bus_addr_s;
  logic [CW-1:0] outst_nxt_s;
  logic [CW-1:0] discard_nxt_s;
  logic          unused_s;

  // Hit/miss classification, issue credits and response accounting.
  always_comb begin
    addr_match_s  = (core_addr_i[31:2] == stream_base_r);
    hit_s         = rst_ni && core_req_i && stream_valid_r && addr_match_s && (count_r != ZERO_C);
    miss_s        = core_req_i && (!stream_valid_r || !addr_match_s);
    // Words already buffered plus live (non-discarded) requests in flight.
    credit_s      = count_r + outst_r - discard_r;
    mem_req_s     = rst_ni && (stale_req_r ||
                    (stream_valid_r && (credit_s < DEPTH_C) && (outst_r < DEPTH_C)));
    mem_gnt_s     = mem_req_s && mem_gnt_i;
    rsp_s         = mem_rvalid_i && (outst_r != ZERO_C);
    push_s        = rsp_s && !miss_s && (discard_r == ZERO_C);
    bus_addr_s    = stale_req_r ? stale_addr_r : fetch_addr_r;
    outst_nxt_s   = outst_r + CW'(mem_gnt_s) - CW'(rsp_s);
    discard_nxt_s = discard_r;
    if (miss_s) begin
      discard_nxt_s = outst_nxt_s;
    end else begin
      discard_nxt_s = discard_r + CW'(mem_gnt_s && stale_req_r)
                    - CW'(rsp_s && (discard_r != ZERO_C));
    end
  end

  // Stream, request and occupancy state; a miss restarts the stream at the core address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stream_valid_r <= 1'b0;
      stream_base_r  <= 30'd0;
      fetch_addr_r   <= 30'd0;
      stale_addr_r   <= 30'd0;
      stale_req_r    <= 1'b0;
      count_r        <= ZERO_C;
      outst_r        <= ZERO_C;
      discard_r      <= ZERO_C;
      rd_ptr_r       <= PW'(0);
      wr_ptr_r       <= PW'(0);
      rdata_r        <= 32'd0;
      rvalid_r       <= 1'b0;
    end else begin
      outst_r   <= outst_nxt_s;
      discard_r <= discard_nxt_s;
      rvalid_r  <= hit_s;
      if (hit_s) begin
        rdata_r <= fifo_r[rd_ptr_r];
      end
      // A request left ungranted by a redirect stays on the bus and is discarded later.
      if (miss_s && mem_req_s && !mem_gnt_i) begin
        stale_req_r  <= 1'b1;
        stale_addr_r <= bus_addr_s;
      end else if (mem_gnt_s && stale_req_r) begin
        stale_req_r  <= 1'b0;
      end
      if (miss_s) begin
        stream_valid_r <= 1'b1;
        stream_base_r  <= core_addr_i[31:2];
        fetch_addr_r   <= core_addr_i[31:2];
        count_r        <= ZERO_C;
        rd_ptr_r       <= PW'(0);
        wr_ptr_r       <= PW'(0);
      end else begin
        if (hit_s) begin
          stream_base_r <= stream_base_r + 30'd1;
        end
        if (mem_gnt_s && !stale_req_r) begin
          fetch_addr_r <= fetch_addr_r + 30'd1;
        end
        count_r  <= count_r + CW'(push_s) - CW'(hit_s);
        rd_ptr_r <= rd_ptr_r + PW'(hit_s);
        wr_ptr_r <= wr_ptr_r + PW'(push_s);
      end
    end
  end

  // Data storage only; occupancy is tracked by count_r, so entries need no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= mem_rdata_i;
    end
  end

  assign unused_s      = ^core_addr_i[1:0];
  assign core_gnt_o    = hit_s;
  assign core_rvalid_o = rvalid_r;
  assign core_rdata_o  = rdata_r;
  assign mem_req_o     = mem_req_s;
  assign mem_addr_o    = {bus_addr_s, 2'b00};

endmodule

// File: doc/imem_prefetch_buf.md
# imem_prefetch_buf

Sequential instruction prefetch buffer between the core's instruction-memory OBI port (`imem_*`) and the instruction memory. It acts as an OBI subordinate to the core and an OBI manager to memory, fetching words ahead of the core into a DEPTH-entry FIFO. Sequential fetches hit with one-cycle latency. A non-sequential address redirects the stream, and stale in-flight responses are discarded.

## Interface
- DEPTH, 4, FIFO entries and max outstanding memory requests; power of two, ≥2
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; synchronous, active-low
- core_req_i  in  1  core fetch request
- core_addr_i  in  32  core fetch address; bits [1:0] ignored
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core_rdata_o valid
- core_rdata_o  out  32  instruction word
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  word-aligned memory address
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data

## Operation
- State:
  - stream_valid_q
  - stream_base_q[31:2]: address of the FIFO head word
  - fetch_addr_q[31:2]: next memory address to request
  - FIFO of data words with count_q
  - outst_q: granted requests not yet returned
  - discard_q: outstanding responses to drop
  - stale_req_q
- FIFO entry i holds the word at stream_base_q+4·i. Responses return in order.
- Hit: core_req_i && stream_valid_q && core_addr_i[31:2]==stream_base_q && count_q>0.
  - core_gnt_o=1.
  - Pop the head into a register.
  - stream_base_q += 1 word.
  - core_rvalid_o=1 with that data next cycle.
- Wait: core address matches stream_base_q but count_q==0. core_gnt_o=0, no flush.
- Miss: core_req_i && (!stream_valid_q || core_addr_i[31:2]!=stream_base_q).
  - core_gnt_o=0.
  - Clear the FIFO.
  - stream_base_q=fetch_addr_q=core_addr_i[31:2].
  - stream_valid_q=1.
  - discard_q = outst_q after this cycle's grant/return accounting.
  - A mem_rvalid_i arriving in the miss cycle is dropped.
  - The core re-presents the request and hits once data arrives.
- Issue rule: mem_req_o = stream_valid_q && (count_q + outst_q − discard_q) < DEPTH && outst_q < DEPTH. mem_addr_o = fetch_addr_q·4.
- On mem_gnt_i: outst_q++ and fetch_addr_q++.
- OBI stability: once asserted, mem_req_o and mem_addr_o are held until mem_gnt_i, including across a miss.
  - If a miss occurs while a request is pending ungranted, set stale_req_q.
  - Keep the old address.
  - On its grant, increment discard_q and clear stale_req_q.
  - The new stream's first request is issued the following cycle.
- On mem_rvalid_i:
  - Always outst_q−−.
  - If discard_q>0: discard_q−− and drop the data.
  - Otherwise: push to the FIFO.
  - If outst_q==0, mem_rvalid_i is ignored (post-reset tolerance).
- Pop and push in the same cycle: count_q unchanged. Full FIFO never receives a push (issue credits guarantee it).
- Counters are ⌈log2(DEPTH)⌉+1 bits. Addresses wrap modulo 2^32.

## Timing
- Reset values:
  - All outputs 0.
  - stream_valid_q=0; count_q, outst_q, discard_q and stale_req_q all 0.
  - No memory request before the first core request.
- Hit latency: gnt same cycle as req; rvalid exactly 1 cycle later. Back-to-back hits sustain 1 word/cycle.
- Miss penalty with zero-wait memory (gnt same cycle, rvalid next):
  - miss at cycle N
  - mem_req at N+1
  - rvalid at N+2, FIFO write at the end of N+2
  - core gnt at N+3
  - core_rvalid at N+4
- No combinational path from mem_* inputs to core_* outputs. core_gnt_o depends only on core inputs and registered state.
- Reset asserted mid-operation: state is cleared on the next edge, and in-flight memory responses are ignored per the outst_q==0 rule.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles with core_req_i=1 -> every output 0 during reset; first miss is processed after release.
- Cold miss at 0x100, zero-wait memory -> mem_req_o at N+1 with addr 0x100, then 0x104, 0x108, 0x10C. core_rvalid_o at N+4 with mem[0x100]. Requests 0x104 and 0x108 are each granted the same cycle, with rvalid on consecutive cycles.
- Full: DEPTH=4, core idle after one hit -> exactly 4 words buffered, and mem_req_o stays 0 until the next pop, after which exactly one new request is issued.
- Redirect with 2 outstanding (memory rvalid delayed 3 cycles), core requests 0x200 -> both stale responses are dropped; the first word delivered is mem[0x200].
- Memory backpressure: mem_gnt_i=0 for 5 cycles, with a redirect to 0x300 during the stall -> mem_addr_o is held at the old address until grant. That response is discarded, and the next request is 0x300.
- Wait case: core requests stream_base while the FIFO is empty with 1 request outstanding -> core_gnt_o=0 and no flush; grant occurs the cycle after the response is written.
